// File: rtl/bp_cce_hybrid_pending_arbiter.sv
// Arbiter between new LCE requests and the pending-queue head, with atomic bursts and a starvation bound.
// Optional grant statistics are enabled by defining BP_CCE_HYBRID_PENDING_ARB_STATS_EN.
module bp_cce_hybrid_pending_arbiter #(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int max_streak_p   = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [header_width_p-1:0] in_header_i,
    input  logic                      in_header_v_i,
    output logic                      in_header_ready_and_o,
    input  logic                      in_has_data_i,
    input  logic [data_width_p-1:0]   in_data_i,
    input  logic                      in_data_v_i,
    output logic                      in_data_ready_and_o,
    input  logic                      in_last_i,
    input  logic [header_width_p-1:0] pq_header_i,
    input  logic                      pq_header_v_i,
    output logic                      pq_header_yumi_o,
    input  logic                      pq_has_data_i,
    input  logic [data_width_p-1:0]   pq_data_i,
    input  logic                      pq_data_v_i,
    output logic                      pq_data_yumi_o,
    input  logic                      pq_last_i,
    input  logic                      pq_block_i,
    output logic [header_width_p-1:0] out_header_o,
    output logic                      out_header_v_o,
    input  logic                      out_header_ready_and_i,
    output logic                      out_has_data_o,
    output logic [data_width_p-1:0]   out_data_o,
    output logic                      out_data_v_o,
    input  logic                      out_data_ready_and_i,
    output logic                      out_last_o,
    output logic                      out_from_pq_o
`ifdef BP_CCE_HYBRID_PENDING_ARB_STATS_EN
    ,
    output logic [31:0]               pq_grants_o,
    output logic [31:0]               in_grants_o,
    output logic [31:0]               starve_events_o
`endif
);

    localparam int streak_w_lp = $clog2(max_streak_p + 1);
    localparam logic [streak_w_lp-1:0] max_streak_lp = streak_w_lp'(max_streak_p);

    typedef enum logic [1:0] {e_ready, e_in_data, e_pq_data} state_e;

    state_e                   state_r, state_n_s;
    logic [streak_w_lp-1:0]   streak_r;
    logic                     pq_elig_s, starve_s, pq_sel_s;
    logic                     header_v_s, in_hdr_ready_s, pq_hdr_yumi_s;
    logic                     data_v_s, in_data_ready_s, pq_data_yumi_s;
    logic                     hdr_fire_s, pq_grant_s, in_grant_s;

    assign pq_elig_s = pq_header_v_i & ~pq_block_i;
    assign starve_s  = (streak_r == max_streak_lp);
    assign pq_sel_s  = pq_elig_s & (~starve_s | ~in_header_v_i);

    // Output muxing and next-state selection for the current burst phase
    always_comb begin
        state_n_s       = state_r;
        out_header_o    = {header_width_p{1'b0}};
        out_has_data_o  = 1'b0;
        out_from_pq_o   = 1'b0;
        header_v_s      = 1'b0;
        in_hdr_ready_s  = 1'b0;
        pq_hdr_yumi_s   = 1'b0;
        out_data_o      = {data_width_p{1'b0}};
        data_v_s        = 1'b0;
        out_last_o      = 1'b0;
        in_data_ready_s = 1'b0;
        pq_data_yumi_s  = 1'b0;
        hdr_fire_s      = 1'b0;
        case (state_r)
            e_ready: begin
                out_header_o   = pq_sel_s ? pq_header_i : in_header_i;
                out_has_data_o = pq_sel_s ? pq_has_data_i : in_has_data_i;
                out_from_pq_o  = pq_sel_s;
                header_v_s     = pq_sel_s | in_header_v_i;
                in_hdr_ready_s = out_header_ready_and_i & ~(pq_elig_s & ~starve_s);
                pq_hdr_yumi_s  = pq_sel_s & out_header_ready_and_i;
                hdr_fire_s     = header_v_s & out_header_ready_and_i;
                if (hdr_fire_s & out_has_data_o) begin
                    state_n_s = pq_sel_s ? e_pq_data : e_in_data;
                end else begin
                    state_n_s = e_ready;
                end
            end
            e_in_data: begin
                out_has_data_o  = 1'b1;
                out_data_o      = in_data_i;
                data_v_s        = in_data_v_i;
                out_last_o      = in_last_i;
                in_data_ready_s = out_data_ready_and_i;
                if (in_data_v_i & out_data_ready_and_i & in_last_i) begin
                    state_n_s = e_ready;
                end else begin
                    state_n_s = e_in_data;
                end
            end
            e_pq_data: begin
                out_has_data_o = 1'b1;
                out_from_pq_o  = 1'b1;
                out_data_o     = pq_data_i;
                data_v_s       = pq_data_v_i;
                out_last_o     = pq_last_i;
                pq_data_yumi_s = pq_data_v_i & out_data_ready_and_i;
                if (pq_data_yumi_s & pq_last_i) begin
                    state_n_s = e_ready;
                end else begin
                    state_n_s = e_pq_data;
                end
            end
            default: begin
                state_n_s = e_ready;
            end
        endcase
    end

    assign pq_grant_s = hdr_fire_s & pq_sel_s;
    assign in_grant_s = hdr_fire_s & ~pq_sel_s;

    // Handshake outputs are forced low while reset is asserted
    assign out_header_v_o        = header_v_s & ~reset_i;
    assign in_header_ready_and_o = in_hdr_ready_s & ~reset_i;
    assign pq_header_yumi_o      = pq_hdr_yumi_s & ~reset_i;
    assign out_data_v_o          = data_v_s & ~reset_i;
    assign in_data_ready_and_o   = in_data_ready_s & ~reset_i;
    assign pq_data_yumi_o        = pq_data_yumi_s & ~reset_i;

    // Burst state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Streak counter only grows while a new request is actually waiting
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            streak_r <= {streak_w_lp{1'b0}};
        end else if (pq_grant_s & in_header_v_i) begin
            streak_r <= starve_s ? streak_r : streak_r + streak_w_lp'(1);
        end else if (hdr_fire_s) begin
            streak_r <= {streak_w_lp{1'b0}};
        end else begin
            streak_r <= streak_r;
        end
    end

`ifdef BP_CCE_HYBRID_PENDING_ARB_STATS_EN
    logic [31:0] pq_grants_r, in_grants_r, starve_events_r;

    // Wrapping grant statistics
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pq_grants_r     <= 32'd0;
            in_grants_r     <= 32'd0;
            starve_events_r <= 32'd0;
        end else begin
            pq_grants_r     <= pq_grant_s ? pq_grants_r + 32'd1 : pq_grants_r;
            in_grants_r     <= in_grant_s ? in_grants_r + 32'd1 : in_grants_r;
            starve_events_r <= (in_grant_s & starve_s) ? starve_events_r + 32'd1 : starve_events_r;
        end
    end

    assign pq_grants_o     = pq_grants_r;
    assign in_grants_o     = in_grants_r;
    assign starve_events_o = starve_events_r;
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_pending_arbiter.sv
// Directed self-checking bench for bp_cce_hybrid_pending_arbiter (default parameters).
module tb_bp_cce_hybrid_pending_arbiter;

    localparam logic [63:0] in_hdr_c = 64'h1111_2222_3333_4444;
    localparam logic [63:0] pq_hdr_c = 64'hAAAA_BBBB_CCCC_DDDD;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] in_header_i, in_data_i, pq_header_i, pq_data_i;
    logic        in_header_v_i, in_has_data_i, in_data_v_i, in_last_i;
    logic        pq_header_v_i, pq_has_data_i, pq_data_v_i, pq_last_i, pq_block_i;
    logic        out_header_ready_and_i, out_data_ready_and_i;
    logic        in_header_ready_and_o, in_data_ready_and_o, pq_header_yumi_o, pq_data_yumi_o;
    logic [63:0] out_header_o, out_data_o;
    logic        out_header_v_o, out_has_data_o, out_data_v_o, out_last_o, out_from_pq_o;
`ifdef BP_CCE_HYBRID_PENDING_ARB_STATS_EN
    logic [31:0] pq_grants_o, in_grants_o, starve_events_o;
`endif

    int checks_r = 0;
    int failures_r = 0;

    always #5 clk_i = ~clk_i;

    bp_cce_hybrid_pending_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .in_header_i(in_header_i), .in_header_v_i(in_header_v_i),
        .in_header_ready_and_o(in_header_ready_and_o), .in_has_data_i(in_has_data_i),
        .in_data_i(in_data_i), .in_data_v_i(in_data_v_i),
        .in_data_ready_and_o(in_data_ready_and_o), .in_last_i(in_last_i),
        .pq_header_i(pq_header_i), .pq_header_v_i(pq_header_v_i),
        .pq_header_yumi_o(pq_header_yumi_o), .pq_has_data_i(pq_has_data_i),
        .pq_data_i(pq_data_i), .pq_data_v_i(pq_data_v_i),
        .pq_data_yumi_o(pq_data_yumi_o), .pq_last_i(pq_last_i), .pq_block_i(pq_block_i),
        .out_header_o(out_header_o), .out_header_v_o(out_header_v_o),
        .out_header_ready_and_i(out_header_ready_and_i), .out_has_data_o(out_has_data_o),
        .out_data_o(out_data_o), .out_data_v_o(out_data_v_o),
        .out_data_ready_and_i(out_data_ready_and_i), .out_last_o(out_last_o),
        .out_from_pq_o(out_from_pq_o)
`ifdef BP_CCE_HYBRID_PENDING_ARB_STATS_EN
        , .pq_grants_o(pq_grants_o), .in_grants_o(in_grants_o), .starve_events_o(starve_events_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_r++;
        if (act !== exp) begin
            failures_r++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    bit inv_tab[19] = '{1,1,1,1,1,1,1,1,1,1, 1,1,1,0,1,1,1,1,1};
    bit pq_tab[19]  = '{1,1,1,1,0,1,1,1,1,0, 1,1,1,1,1,1,1,1,0};
    bit post_tab[5] = '{1,1,1,1,0};

    initial begin
        int beat;
        int yumis;
        bit r;
        reset_i = 1'b1;
        in_header_i = in_hdr_c; pq_header_i = pq_hdr_c;
        in_data_i = 64'd0; pq_data_i = 64'd0;
        in_header_v_i = 1'b1; pq_header_v_i = 1'b1;
        in_has_data_i = 1'b0; pq_has_data_i = 1'b0;
        in_data_v_i = 1'b0; pq_data_v_i = 1'b0;
        in_last_i = 1'b0; pq_last_i = 1'b0; pq_block_i = 1'b0;
        out_header_ready_and_i = 1'b1; out_data_ready_and_i = 1'b1;

        // reset: handshakes suppressed even with both sources valid
        @(negedge clk_i);
        check_eq("rst_hdr_v", out_header_v_o, 64'd0);
        check_eq("rst_in_ready", in_header_ready_and_o, 64'd0);
        check_eq("rst_pq_yumi", pq_header_yumi_o, 64'd0);
        check_eq("rst_data_v", out_data_v_o, 64'd0);
        next_cycle();
        reset_i = 1'b0;

        // priority with starvation bound, then streak clear on pq grant with in idle
        for (int i = 0; i < 19; i++) begin
            in_header_v_i = inv_tab[i];
            @(negedge clk_i);
            check_eq($sformatf("prio_from_pq[%0d]", i), out_from_pq_o, 64'(pq_tab[i]));
            check_eq($sformatf("prio_pq_yumi[%0d]", i), pq_header_yumi_o, 64'(pq_tab[i]));
            check_eq($sformatf("prio_in_ready[%0d]", i), in_header_ready_and_o, 64'(!pq_tab[i]));
            check_eq($sformatf("prio_hdr[%0d]", i), out_header_o, pq_tab[i] ? pq_hdr_c : in_hdr_c);
            next_cycle();
`ifdef BP_CCE_HYBRID_PENDING_ARB_STATS_EN
            if (i == 9) begin
                check_eq("stats_pq", 64'(pq_grants_o), 64'd8);
                check_eq("stats_in", 64'(in_grants_o), 64'd2);
                check_eq("stats_starve", 64'(starve_events_o), 64'd2);
            end
`endif
        end

        // blocked head is skipped, then granted once unblocked
        pq_block_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq("blk_in_ready", in_header_ready_and_o, 64'd1);
            check_eq("blk_pq_yumi", pq_header_yumi_o, 64'd0);
            next_cycle();
        end
        pq_block_i = 1'b0;
        @(negedge clk_i);
        check_eq("unblk_pq_yumi", pq_header_yumi_o, 64'd1);
        next_cycle();

        // atomic 4-beat pq burst with toggling downstream data ready
        pq_has_data_i = 1'b1;
        @(negedge clk_i);
        check_eq("burst_hdr_yumi", pq_header_yumi_o, 64'd1);
        check_eq("burst_has_data", out_has_data_o, 64'd1);
        next_cycle();
        pq_header_v_i = 1'b0;
        pq_has_data_i = 1'b0;
        pq_data_v_i = 1'b1;
        beat = 0;
        yumis = 0;
        for (int i = 0; i < 7; i++) begin
            r = (i % 2 == 0);
            out_data_ready_and_i = r;
            pq_last_i = (beat == 3);
            pq_data_i = 64'(100 + beat);
            @(negedge clk_i);
            check_eq($sformatf("burst_yumi[%0d]", i), pq_data_yumi_o, 64'(r));
            check_eq($sformatf("burst_last[%0d]", i), out_last_o, 64'(beat == 3));
            check_eq($sformatf("burst_data[%0d]", i), out_data_o, 64'(100 + beat));
            check_eq($sformatf("burst_in_ready[%0d]", i), in_header_ready_and_o, 64'd0);
            check_eq($sformatf("burst_hdr_v[%0d]", i), out_header_v_o, 64'd0);
            if (pq_data_yumi_o) yumis++;
            if (r) beat++;
            next_cycle();
        end
        check_eq("burst_yumi_count", 64'(yumis), 64'd4);
        pq_data_v_i = 1'b0;
        pq_last_i = 1'b0;
        out_data_ready_and_i = 1'b1;
        @(negedge clk_i);
        check_eq("post_burst_in_ready", in_header_ready_and_o, 64'd1);
        check_eq("post_burst_data_v", out_data_v_o, 64'd0);
        check_eq("post_burst_from_pq", out_from_pq_o, 64'd0);
        next_cycle();

        // downstream header stall
        pq_header_v_i = 1'b1;
        out_header_ready_and_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq("stall_in_ready", in_header_ready_and_o, 64'd0);
            check_eq("stall_pq_yumi", pq_header_yumi_o, 64'd0);
            check_eq("stall_hdr", out_header_o, pq_hdr_c);
            next_cycle();
        end
        out_header_ready_and_i = 1'b1;
        @(negedge clk_i);
        check_eq("stall_release_yumi", pq_header_yumi_o, 64'd1);
        next_cycle();

        // reset during beat 2 of an in burst
        pq_header_v_i = 1'b0;
        in_has_data_i = 1'b1;
        @(negedge clk_i);
        check_eq("rb_hdr_ready", in_header_ready_and_o, 64'd1);
        next_cycle();
        in_has_data_i = 1'b0;
        in_data_v_i = 1'b1;
        @(negedge clk_i);
        check_eq("rb_beat1_ready", in_data_ready_and_o, 64'd1);
        check_eq("rb_beat1_v", out_data_v_o, 64'd1);
        next_cycle();
        reset_i = 1'b1;
        @(negedge clk_i);
        check_eq("rb_rst_data_v", out_data_v_o, 64'd0);
        check_eq("rb_rst_data_ready", in_data_ready_and_o, 64'd0);
        check_eq("rb_rst_hdr_v", out_header_v_o, 64'd0);
        check_eq("rb_rst_hdr_ready", in_header_ready_and_o, 64'd0);
        next_cycle();
        reset_i = 1'b0;
        pq_header_v_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq($sformatf("rb_post_from_pq[%0d]", i), out_from_pq_o, 64'(post_tab[i]));
            check_eq($sformatf("rb_post_data_v[%0d]", i), out_data_v_o, 64'd0);
            check_eq($sformatf("rb_post_hdr_v[%0d]", i), out_header_v_o, 64'd1);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
